// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: memory op encoding and FSM states.
package core_package;

    typedef enum logic [2:0] {
        LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU, LSU_SB, LSU_SH, LSU_SW
    } lsu_op_e;

    typedef enum logic [1:0] {
        LSU_IDLE, LSU_REQ, LSU_WAIT
    } lsu_state_e;

    function automatic logic is_store(lsu_op_e op);
        return (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational lane logic: store byte-enable/data steering and misalignment check
// for the incoming op, plus byte/half extraction and extension for the latched load.
module lsu_align
    import core_package::*;
(
    input  lsu_op_e     st_op_i,
    input  logic [1:0]  st_addr_i,
    input  logic [31:0] wdata_i,
    input  lsu_op_e     ld_op_i,
    input  logic [1:0]  ld_addr_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic        misaligned_o,
    output logic [31:0] ld_data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        be_o         = 4'b1111;
        wdata_o      = wdata_i;
        misaligned_o = 1'b0;
        case (st_op_i)
            LSU_LB, LSU_LBU, LSU_SB: begin
                be_o    = 4'b0001 << st_addr_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            LSU_LH, LSU_LHU, LSU_SH: begin
                be_o         = st_addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_o      = {2{wdata_i[15:0]}};
                misaligned_o = st_addr_i[0];
            end
            default: begin
                misaligned_o = |st_addr_i;
            end
        endcase
    end

    always_comb begin
        case (ld_addr_i)
            2'd0:    byte_v = rdata_i[7:0];
            2'd1:    byte_v = rdata_i[15:8];
            2'd2:    byte_v = rdata_i[23:16];
            default: byte_v = rdata_i[31:24];
        endcase
        half_v = ld_addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (ld_op_i)
            LSU_LB:  ld_data_o = {{24{byte_v[7]}}, byte_v};
            LSU_LBU: ld_data_o = {24'd0, byte_v};
            LSU_LH:  ld_data_o = {{16{half_v[15]}}, half_v};
            LSU_LHU: ld_data_o = {16'd0, half_v};
            default: ld_data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: accepts one op from execute, runs a req/gnt/rvalid transaction on the
// data port and returns extended load data to writeback. All outputs are registered.
module load_store_unit
    import core_package::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    output logic              ready_o,
    input  lsu_op_e           op_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    input  logic [4:0]        rd_i,
    output logic              req_o,
    input  logic              gnt_i,
    output logic              we_o,
    output logic [3:0]        be_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [31:0]       wdata_o,
    input  logic              rvalid_i,
    input  logic [31:0]       rdata_i,
    output logic              wb_valid_o,
    output logic [4:0]        wb_rd_o,
    output logic [31:0]       wb_data_o,
    output logic              done_o,
    output logic              misaligned_o,
    output logic [1:0]        dbg_state_o
);

    lsu_state_e        state_q, state_d;
    lsu_op_e           op_q, op_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic [4:0]        rd_q, rd_d;
    logic              req_q, req_d, we_q, we_d;
    logic [3:0]        be_q, be_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d, wb_data_q, wb_data_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic              wb_valid_q, wb_valid_d, done_q, done_d, mis_q, mis_d;

    logic [3:0]  al_be;
    logic [31:0] al_wdata, al_ld_data;
    logic        al_mis;

    lsu_align u_align (
        .st_op_i      (op_i),
        .st_addr_i    (addr_i[1:0]),
        .wdata_i      (wdata_i),
        .ld_op_i      (op_q),
        .ld_addr_i    (addr_lo_q),
        .rdata_i      (rdata_i),
        .be_o         (al_be),
        .wdata_o      (al_wdata),
        .misaligned_o (al_mis),
        .ld_data_o    (al_ld_data)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= LSU_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LSU_IDLE: if (valid_i && !al_mis) state_d = LSU_REQ;
            LSU_REQ:  if (gnt_i)              state_d = LSU_WAIT;
            LSU_WAIT: if (rvalid_i)           state_d = LSU_IDLE;
            default:                          state_d = LSU_IDLE;
        endcase
    end

    // Port and writeback values hold between transactions; only the pulses default low.
    always_comb begin
        op_d       = op_q;
        addr_lo_d  = addr_lo_q;
        rd_d       = rd_q;
        req_d      = req_q;
        we_d       = we_q;
        be_d       = be_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        wb_valid_d = 1'b0;
        done_d     = 1'b0;
        mis_d      = 1'b0;
        case (state_q)
            LSU_IDLE: begin
                if (valid_i) begin
                    op_d      = op_i;
                    addr_lo_d = addr_i[1:0];
                    rd_d      = rd_i;
                    if (al_mis) begin
                        done_d = 1'b1;
                        mis_d  = 1'b1;
                    end else begin
                        req_d   = 1'b1;
                        we_d    = is_store(op_i);
                        be_d    = al_be;
                        addr_d  = {addr_i[ADDR_W-1:2], 2'b00};
                        wdata_d = al_wdata;
                    end
                end
            end
            LSU_REQ: begin
                if (gnt_i) req_d = 1'b0;
            end
            LSU_WAIT: begin
                if (rvalid_i) begin
                    done_d = 1'b1;
                    if (!is_store(op_q)) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_q;
                        wb_data_d  = al_ld_data;
                    end
                end
            end
            default: req_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            op_q       <= LSU_LB;
            addr_lo_q  <= 2'd0;
            rd_q       <= 5'd0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            be_q       <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= 32'd0;
            wb_valid_q <= 1'b0;
            done_q     <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            op_q       <= op_d;
            addr_lo_q  <= addr_lo_d;
            rd_q       <= rd_d;
            req_q      <= req_d;
            we_q       <= we_d;
            be_q       <= be_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            wb_valid_q <= wb_valid_d;
            done_q     <= done_d;
            mis_q      <= mis_d;
        end
    end

    assign ready_o      = (state_q == LSU_IDLE);
    assign req_o        = req_q;
    assign we_o         = we_q;
    assign be_o         = be_q;
    assign addr_o       = addr_q;
    assign wdata_o      = wdata_q;
    assign wb_valid_o   = wb_valid_q;
    assign wb_rd_o      = wb_rd_q;
    assign wb_data_o    = wb_data_q;
    assign done_o       = done_q;
    assign misaligned_o = mis_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a vector table for single transactions with
// programmable gnt/rvalid delays, plus hand sequences for back-to-back and reset cases.
module tb_load_store_unit;
    import core_package::*;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    lsu_op_e     op_i = LSU_LB;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic [4:0]  rd_i = '0;
    logic        req_o;
    logic        gnt_i = 1'b0;
    logic        we_o;
    logic [3:0]  be_o;
    logic [31:0] addr_o;
    logic [31:0] wdata_o;
    logic        rvalid_i = 1'b0;
    logic [31:0] rdata_i = '0;
    logic        wb_valid_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        done_o;
    logic        misaligned_o;
    logic [1:0]  dbg_state_o;

    load_store_unit #(.ADDR_W(32)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
        .op_i(op_i), .addr_i(addr_i), .wdata_i(wdata_i), .rd_i(rd_i),
        .req_o(req_o), .gnt_i(gnt_i), .we_o(we_o), .be_o(be_o), .addr_o(addr_o),
        .wdata_o(wdata_o), .rvalid_i(rvalid_i), .rdata_i(rdata_i),
        .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
        .done_o(done_o), .misaligned_o(misaligned_o), .dbg_state_o(dbg_state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        lsu_op_e     op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [4:0]  rd;
        int          gnt_dly;
        int          rv_dly;
        logic        mis;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdo;
        logic [31:0] wb;
    } vec_t;

    vec_t        vecs[15];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] last_wb = '0;
    logic [4:0]  last_rd = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx);
        vec_t        v;
        int          req_cnt, wait_cnt, lat;
        logic        done_seen, granted, stable_ok, is_load;
        logic        s_mis, s_wbv, s_we;
        logic [31:0] s_wbd, s_addr, s_wdata;
        logic [4:0]  s_rd;
        logic [3:0]  s_be;
        v = vecs[idx];
        req_cnt = 0; wait_cnt = 0; lat = 0;
        done_seen = 0; granted = 0; stable_ok = 1;
        s_mis = 0; s_wbv = 0; s_we = 0; s_wbd = '0; s_addr = '0; s_wdata = '0; s_rd = '0; s_be = '0;
        is_load = !v.mis && !v.we;
        @(negedge clk);
        valid_i = 1'b1; op_i = v.op; addr_i = v.addr; wdata_i = v.wdata;
        rd_i = v.rd; rdata_i = v.rdata;
        for (int c = 1; c <= 60 && !done_seen; c++) begin
            @(negedge clk);
            valid_i = 1'b0; gnt_i = 1'b0; rvalid_i = 1'b0;
            if (done_o) begin
                done_seen = 1; lat = c;
                s_mis = misaligned_o; s_wbv = wb_valid_o; s_wbd = wb_data_o; s_rd = wb_rd_o;
            end else if (req_o) begin
                req_cnt++;
                if (ready_o) stable_ok = 0;
                if (req_cnt == 1) begin
                    s_be = be_o; s_addr = addr_o; s_wdata = wdata_o; s_we = we_o;
                end else if (be_o !== s_be || addr_o !== s_addr || wdata_o !== s_wdata || we_o !== s_we) begin
                    stable_ok = 0;
                end
                if (req_cnt == v.gnt_dly + 1) begin
                    gnt_i = 1'b1; granted = 1;
                end
            end else if (granted) begin
                wait_cnt++;
                if (wait_cnt == v.rv_dly + 1) rvalid_i = 1'b1;
            end
        end
        check($sformatf("v%0d done_seen", idx), 32'(done_seen), 32'd1);
        check($sformatf("v%0d latency", idx), lat, v.mis ? 1 : v.gnt_dly + v.rv_dly + 3);
        check($sformatf("v%0d req_cycles", idx), req_cnt, v.mis ? 0 : v.gnt_dly + 1);
        check($sformatf("v%0d misaligned", idx), 32'(s_mis), 32'(v.mis));
        if (!v.mis) begin
            check($sformatf("v%0d be", idx), 32'(s_be), 32'(v.be));
            check($sformatf("v%0d addr_o", idx), s_addr, v.addr & ~32'h3);
            check($sformatf("v%0d wdata_o", idx), s_wdata, v.wdo);
            check($sformatf("v%0d we", idx), 32'(s_we), 32'(v.we));
            check($sformatf("v%0d req_stable", idx), 32'(stable_ok), 32'd1);
        end
        if (is_load) begin
            last_wb = v.wb;
            last_rd = v.rd;
        end
        check($sformatf("v%0d wb_valid", idx), 32'(s_wbv), 32'(is_load));
        check($sformatf("v%0d wb_data", idx), s_wbd, last_wb);
        check($sformatf("v%0d wb_rd", idx), 32'(s_rd), 32'(last_rd));
        @(negedge clk);
        check($sformatf("v%0d pulse_end", idx), {29'd0, done_o, wb_valid_o, misaligned_o}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation watchdog expired");
    end

    initial begin
        //          op       addr       wdata         rdata         rd  g  r  mis we be    wdo           wb
        vecs[0]  = '{LSU_SW,  32'h100, 32'hDEADBEEF, 32'h0,        0,  0, 0, 0, 1, 4'hF, 32'hDEADBEEF, 32'h0};
        vecs[1]  = '{LSU_SB,  32'h103, 32'h000000AB, 32'h0,        0,  0, 0, 0, 1, 4'h8, 32'hABABABAB, 32'h0};
        vecs[2]  = '{LSU_LB,  32'h202, 32'h0,        32'h12803456, 5,  0, 0, 0, 0, 4'h4, 32'h0,        32'hFFFFFF80};
        vecs[3]  = '{LSU_LBU, 32'h202, 32'h0,        32'h12803456, 6,  1, 1, 0, 0, 4'h4, 32'h0,        32'h00000080};
        vecs[4]  = '{LSU_LH,  32'h203, 32'h0,        32'h0,        3,  0, 0, 1, 0, 4'h0, 32'h0,        32'h0};
        vecs[5]  = '{LSU_LW,  32'h304, 32'h0,        32'hCAFEF00D, 10, 4, 2, 0, 0, 4'hF, 32'h0,        32'hCAFEF00D};
        vecs[6]  = '{LSU_LH,  32'h206, 32'h0,        32'h80017FFF, 11, 0, 3, 0, 0, 4'hC, 32'h0,        32'hFFFF8001};
        vecs[7]  = '{LSU_LHU, 32'h200, 32'h0,        32'h12349ABC, 12, 2, 0, 0, 0, 4'h3, 32'h0,        32'h00009ABC};
        vecs[8]  = '{LSU_SH,  32'h102, 32'h1111BEEF, 32'h0,        0,  1, 0, 0, 1, 4'hC, 32'hBEEFBEEF, 32'h0};
        vecs[9]  = '{LSU_SW,  32'h101, 32'h11111111, 32'h0,        0,  0, 0, 1, 1, 4'h0, 32'h0,        32'h0};
        vecs[10] = '{LSU_LW,  32'h10A, 32'h0,        32'h0,        4,  0, 0, 1, 0, 4'h0, 32'h0,        32'h0};
        vecs[11] = '{LSU_LB,  32'h001, 32'h0,        32'h00007F00, 13, 0, 0, 0, 0, 4'h2, 32'h0,        32'h0000007F};
        vecs[12] = '{LSU_SB,  32'h000, 32'hFFFFFF5A, 32'h0,        0,  0, 1, 0, 1, 4'h1, 32'h5A5A5A5A, 32'h0};
        vecs[13] = '{LSU_LHU, 32'h201, 32'h0,        32'h0,        8,  0, 0, 1, 0, 4'h0, 32'h0,        32'h0};
        vecs[14] = '{LSU_SW,  32'h202, 32'h12345678, 32'h0,        0,  0, 0, 1, 1, 4'h0, 32'h0,        32'h0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst ready", 32'(ready_o), 32'd1);
        check("rst pulses", {28'd0, req_o, we_o, done_o, wb_valid_o | misaligned_o}, 32'd0);
        check("rst be_addr", {be_o, addr_o[27:0]}, 32'd0);
        check("rst wdata", wdata_o, 32'd0);
        check("rst wb", {wb_rd_o, wb_data_o[26:0]}, 32'd0);
        rst_ni = 1'b1;

        for (int i = 0; i < 15; i++) run_vec(i);

        // Misaligned op, then a load accepted in the same cycle done_o pulses
        @(negedge clk);
        valid_i = 1'b1; op_i = LSU_LH; addr_i = 32'h203; rd_i = 5'd2;
        @(negedge clk);
        check("b2b mis_done", {30'd0, done_o, misaligned_o}, 32'd3);
        check("b2b ready", 32'(ready_o), 32'd1);
        op_i = LSU_LW; addr_i = 32'h300; rd_i = 5'd7; rdata_i = 32'h0BADF00D;
        @(negedge clk);
        valid_i = 1'b0;
        check("b2b req", {31'd0, req_o}, 32'd1);
        check("b2b addr", addr_o, 32'h300);
        gnt_i = 1'b1;
        @(negedge clk);
        gnt_i = 1'b0; rvalid_i = 1'b1;
        check("b2b req_drop", {31'd0, req_o}, 32'd0);
        @(negedge clk);
        rvalid_i = 1'b0;
        check("b2b ld_done", {30'd0, done_o, wb_valid_o}, 32'd3);
        check("b2b ld_data", wb_data_o, 32'h0BADF00D);
        check("b2b ld_rd", 32'(wb_rd_o), 32'd7);
        // Store accepted in the same cycle the load's done_o pulses
        valid_i = 1'b1; op_i = LSU_SB; addr_i = 32'h001; wdata_i = 32'h00000033;
        @(negedge clk);
        valid_i = 1'b0;
        check("b2b st_req", {31'd0, req_o}, 32'd1);
        check("b2b st_be", 32'(be_o), 32'h2);
        check("b2b st_wdata", wdata_o, 32'h33333333);
        gnt_i = 1'b1;
        @(negedge clk);
        gnt_i = 1'b0; rvalid_i = 1'b1;
        @(negedge clk);
        rvalid_i = 1'b0;
        check("b2b st_done", {30'd0, done_o, wb_valid_o}, 32'd2);
        check("b2b wb_hold", wb_data_o, 32'h0BADF00D);

        // Reset while in REQ: req_o drops at the next edge
        @(negedge clk);
        valid_i = 1'b1; op_i = LSU_LW; addr_i = 32'h400;
        @(negedge clk);
        valid_i = 1'b0;
        check("rreq req", {31'd0, req_o}, 32'd1);
        rst_ni = 1'b0;
        @(negedge clk);
        check("rreq req_drop", {31'd0, req_o}, 32'd0);
        check("rreq ready", 32'(ready_o), 32'd1);
        rst_ni = 1'b1;

        // Reset while in WAIT, then a late rvalid_i must be discarded
        @(negedge clk);
        valid_i = 1'b1; op_i = LSU_LW; addr_i = 32'h500; rd_i = 5'd9; rdata_i = 32'h55555555;
        @(negedge clk);
        valid_i = 1'b0; gnt_i = 1'b1;
        @(negedge clk);
        gnt_i = 1'b0;
        check("rwait in_wait", {30'd0, req_o, ready_o}, 32'd0);
        rst_ni = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1; rvalid_i = 1'b1;
        @(negedge clk);
        rvalid_i = 1'b0;
        check("rwait no_pulse", {30'd0, done_o, wb_valid_o}, 32'd0);
        check("rwait ready", 32'(ready_o), 32'd1);
        check("rwait wb_cleared", wb_data_o, 32'd0);
        @(negedge clk);
        check("rwait still_quiet", {29'd0, done_o, wb_valid_o, req_o}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
